// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcodes, FSM states and shared constants for alu_pipe
package alu_pipe_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00011;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_NOR  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SRA  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROTR = 5'b00111;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_NAND = 5'b01001;
  localparam logic [OPC_W-1:0] OP_MAX  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MIN  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ABS  = 5'b01100;
  localparam logic [OPC_W-1:0] OP_SLTS = 5'b01101;
  localparam logic [OPC_W-1:0] OP_SLL  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_ROTL = 5'b01111;
  localparam logic [OPC_W-1:0] OP_ADDU = 5'b10000;
  localparam logic [OPC_W-1:0] OP_SRLU = 5'b10001;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_RUN  = 2'd1,
    ST_MUL_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// rtl/alu_pipe_mul.sv - iterative shift-add unsigned multiplier, one partial product per cycle
module alu_pipe_mul
  import alu_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_prod
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] r_prod;
  logic [DATA_W-1:0]   r_mcand;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic [DATA_W:0]     w_sum;
  logic                w_last;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  assign w_sum  = {1'b0, r_prod[2*DATA_W-1:DATA_W]} +
                  (r_prod[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});
  assign w_last = r_busy && (r_cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_prod  <= {{DATA_W{1'b0}}, i_b};
      r_mcand <= i_a;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_prod  <= {w_sum, r_prod[DATA_W-1:1]};
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_last;
  assign o_prod = r_prod;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU with sticky overflow
// Optional multi-cycle MUL enabled by defining ALU_MUL_EN.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_overflow,
  output logic              alu_illegal,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t r_state;
  state_t w_state_nxt;

  logic              r_valid;
  logic [DATA_W-1:0] r_out;
  logic              r_ovf;
  logic              r_ill;
  logic              r_sticky;

  logic [SH_W-1:0]     w_sh;
  logic [2*DATA_W-1:0] w_dbl;
  logic [2*DATA_W-1:0] w_rotr_full;
  logic [2*DATA_W-1:0] w_rotl_full;
  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic [DATA_W-1:0]   w_neg;
  logic [DATA_W:0]     w_addu;
  logic                w_lt;

  logic [DATA_W-1:0] w_res;
  logic              w_ovf;
  logic              w_ill;
  logic              w_is_mul;

  logic                w_accept;
  logic                w_load_alu;
  logic                w_load_mul;
  logic                w_mul_start;
  logic                w_mul_busy;
  logic                w_mul_done;
  logic [2*DATA_W-1:0] w_mul_prod;

  assign w_sh        = src2[SH_W-1:0];
  assign w_dbl       = {src1, src1};
  assign w_rotr_full = w_dbl >> w_sh;
  assign w_rotl_full = w_dbl << w_sh;
  assign w_sum       = src1 + src2;
  assign w_diff      = src1 - src2;
  assign w_neg       = '0 - src1;
  assign w_addu      = {1'b0, src1} + {1'b0, src2};
  assign w_lt        = $signed(src1) < $signed(src2);

  always_comb begin
    w_res    = '0;
    w_ovf    = 1'b0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
    case (alu_op)
      OP_W'(OP_ADD): begin
        w_res = w_sum;
        w_ovf = (src1[DATA_W-1] == src2[DATA_W-1]) && (w_sum[DATA_W-1] != src1[DATA_W-1]);
      end
      OP_W'(OP_SUB): begin
        w_res = w_diff;
        w_ovf = (src1[DATA_W-1] != src2[DATA_W-1]) && (w_diff[DATA_W-1] != src1[DATA_W-1]);
      end
      OP_W'(OP_AND):  w_res = src1 & src2;
      OP_W'(OP_OR):   w_res = src1 | src2;
      OP_W'(OP_XOR):  w_res = src1 ^ src2;
      OP_W'(OP_NOR):  w_res = ~(src1 | src2);
      OP_W'(OP_SRA):  w_res = $signed(src1) >>> w_sh;
      OP_W'(OP_ROTR): w_res = w_rotr_full[DATA_W-1:0];
      OP_W'(OP_NOT):  w_res = ~src1;
      OP_W'(OP_NAND): w_res = ~(src1 & src2);
      OP_W'(OP_MAX):  w_res = w_lt ? src2 : src1;
      OP_W'(OP_MIN):  w_res = w_lt ? src1 : src2;
      OP_W'(OP_ABS): begin
        // Negating the most-negative value wraps back to itself; flag it.
        w_res = src1[DATA_W-1] ? w_neg : src1;
        w_ovf = (src1 == MOST_NEG);
      end
      OP_W'(OP_SLTS): w_res = {{(DATA_W-1){1'b0}}, w_lt};
      OP_W'(OP_SLL):  w_res = src1 << w_sh;
      OP_W'(OP_ROTL): w_res = w_rotl_full[2*DATA_W-1:DATA_W];
      OP_W'(OP_ADDU): begin
        w_res = w_addu[DATA_W-1:0];
        w_ovf = w_addu[DATA_W];
      end
      OP_W'(OP_SRLU): w_res = src1 >> w_sh;
`ifdef ALU_MUL_EN
      OP_W'(OP_MUL):  w_is_mul = 1'b1;
`endif
      default:        w_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_pipe_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mul_start),
    .i_a     (src1),
    .i_b     (src2),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );
`else
  assign w_mul_busy = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = '0;
`endif

  assign in_ready = (r_state == ST_IDLE) && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_alu  = 1'b0;
    w_load_mul  = 1'b0;
    w_mul_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_mul_start = 1'b1;
            w_state_nxt = ST_MUL_RUN;
          end else begin
            w_load_alu = 1'b1;
          end
        end
      end
      ST_MUL_RUN: begin
        if (w_mul_done || !w_mul_busy) begin
          w_state_nxt = ST_MUL_DONE;
        end
      end
      ST_MUL_DONE: begin
        if (!r_valid || out_ready) begin
          w_load_mul  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_ill   <= 1'b0;
    end else if (w_load_alu) begin
      r_valid <= 1'b1;
      r_out   <= w_res;
      r_ovf   <= w_ovf;
      r_ill   <= w_ill;
    end else if (w_load_mul) begin
      r_valid <= 1'b1;
      r_out   <= w_mul_prod[DATA_W-1:0];
      r_ovf   <= |w_mul_prod[2*DATA_W-1:DATA_W];
      r_ill   <= 1'b0;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // A set from a consumed overflow result takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (r_valid && out_ready && r_ovf) begin
      r_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign out_valid    = r_valid;
  assign alu_out      = r_out;
  assign alu_overflow = r_ovf;
  assign alu_illegal  = r_ill;
  assign ovf_sticky   = r_sticky;

endmodule
